// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per cycle through a half-adder pair slice,
// wrapped in a valid/ready handshake on both the operand and the result side.

// Half adder: the building block of the per-bit slice.
module ha (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

// Serial adder top.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // A 1-bit counter still indexes both bits when WIDTH is 2.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Per-bit slice: two half adders plus an OR for the carry.
  logic ha0_s, ha0_c, ha1_c;
  logic bit_sum, bit_carry;

  ha u_ha0 (
    .a_i (a_q[0]),
    .b_i (b_q[0]),
    .s_o (ha0_s),
    .c_o (ha0_c)
  );

  ha u_ha1 (
    .a_i (ha0_s),
    .b_i (carry_q),
    .s_o (bit_sum),
    .c_o (ha1_c)
  );

  assign bit_carry = ha0_c | ha1_c;

  // Next-state and handshake decode; an accept in IDLE or DONE loads operands.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = {bit_sum, sum_q[WIDTH-1:1]};
        carry_d = bit_carry;
        if (cnt_q == CNT_LAST) begin
          // Hold the counter on the last bit so it never wraps.
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Result retires and new operands may enter on the same edge.
        in_ready  = out_ready;
        if (out_ready && !in_valid) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (in_valid && in_ready) begin
      a_d     = a;
      b_d     = b;
      carry_d = cin;
      sum_d   = '0;
      cnt_d   = '0;
      state_d = RUN;
    end
  end

  // State and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized checks of serial_adder at WIDTH=8.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;

  int checks = 0;
  int errors = 0;

  serial_adder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called #1 after a rising edge with the block idle.
  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tbv,
                       input logic tc, input int stall, input logic [8:0] exp);
    int lat;
    a = ta; b = tbv; cin = tc; in_valid = 1'b1;
    out_ready = (stall == 0);
    #1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble operands: the in-flight result must not notice.
    a = ~ta; b = ~tbv; cin = ~tc;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, 8);
    check({tag, "_result"}, {cout, sum}, exp);
    repeat (stall) begin
      @(posedge clk); #1;
      check({tag, "_stall_valid"}, out_valid, 1);
      check({tag, "_stall_result"}, {cout, sum}, exp);
      check({tag, "_stall_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    #1;
    check({tag, "_done_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_retired_valid"}, out_valid, 0);
    check({tag, "_retired_in_ready"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    int seen;
    int done_n;
    int cyc;
    logic acc;
    logic ret;
    logic [8:0] expv;
    logic [8:0] q[$];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_result", {cout, sum}, 9'h000);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero operands with out_ready held high.
    do_op("zero", 8'h00, 8'h00, 1'b0, 0, 9'h000);
    // Carry ripples out of every bit.
    do_op("ff_01", 8'hFF, 8'h01, 1'b0, 0, 9'h100);
    do_op("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 0, 9'h1FF);
    // Five cycles of backpressure in DONE.
    do_op("bp", 8'h5A, 8'h3C, 1'b0, 5, 9'h096);

    // Back-to-back: second operand set enters on the retire edge.
    a = 8'h12; b = 8'h34; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 8'h80; b = 8'h80; cin = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_first_latency", lat, 8);
    check("b2b_first_result", {cout, sum}, 9'h046);
    check("b2b_first_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_no_bubble_valid", out_valid, 0);
    check("b2b_no_bubble_in_ready", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("b2b_second_latency", lat, 8);
    check("b2b_second_result", {cout, sum}, 9'h100);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("b2b_idle_in_ready", in_ready, 1);

    // Reset three cycles into an operation aborts it; in_valid in that cycle is dropped.
    a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_result", {cout, sum}, 9'h000);
    out_ready = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    check("abort_no_result", seen, 0);
    check("abort_still_idle", in_ready, 1);
    do_op("post_reset", 8'h01, 8'h01, 1'b0, 0, 9'h002);

    // Randomized traffic with a scoreboard of a+b+cin.
    in_valid = 1'b0; out_ready = 1'b0;
    done_n = 0; cyc = 0;
    while (done_n < 1000 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (ret) begin
        if (q.size() == 0) begin
          check("rnd_spurious_result", 1, 0);
        end else begin
          expv = q.pop_front();
          check("rnd_result", {cout, sum}, expv);
        end
        done_n++;
      end
      if (acc) q.push_back(9'(a) + 9'(b) + 9'(cin));
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        in_valid = 1'($urandom_range(0, 1));
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom_range(0, 1));
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    check("rnd_completed", done_n, 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the operand width in bits (legal range 2..64).
REQ-002 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, width 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The block SHALL have port in_valid, input, width 1: upstream asserts when the operand set is valid.
REQ-005 The block SHALL have port in_ready, output, width 1: the block can accept an operand set this cycle.
REQ-006 The block SHALL have port a, input, width WIDTH: operand A.
REQ-007 The block SHALL have port b, input, width WIDTH: operand B.
REQ-008 The block SHALL have port cin, input, width 1: carry-in.
REQ-009 The block SHALL have port out_valid, output, width 1: sum and cout hold a valid result.
REQ-010 The block SHALL have port out_ready, input, width 1: downstream accepts the result this cycle.
REQ-011 The block SHALL have port sum, output, width WIDTH: result, equal to (a+b+cin) mod 2^WIDTH.
REQ-012 The block SHALL have port cout, output, width 1: carry-out, equal to bit WIDTH of a+b+cin.

Function
REQ-013 The per-bit slice SHALL be built from two instances of the existing ha half adder plus one OR gate for the carry, computing exactly one bit per RUN cycle.
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 In IDLE, in_ready=1 and out_valid=0.
REQ-016 On an accept (in_valid&&in_ready) in IDLE, the block SHALL capture a, b and cin into shift/carry registers, clear the bit counter to 0, and go to RUN.
REQ-017 In RUN, each cycle the block SHALL add the operand LSBs with the carry register, shift the sum bit into the result MSB while shifting right, update the carry, and increment the counter; in_ready=0 and out_valid=0.
REQ-018 When the counter reaches WIDTH-1 in RUN, the block SHALL go to DONE on the next edge, with sum holding the full result and cout holding the final carry.
REQ-019 Latency: if an accept occurs on edge E, out_valid SHALL be first high in the cycle after edge E+WIDTH.
REQ-020 In DONE, out_valid=1, and sum/cout SHALL stay stable until out_ready=1 (backpressure of any length).
REQ-021 In DONE, in_ready SHALL equal out_ready, so a new operand set can be accepted in the same cycle the result is consumed.
REQ-022 Simultaneous out_ready&&in_valid in DONE: the result is retired, the new operands are captured, and the next state is RUN with no idle bubble.
REQ-023 When out_ready=1 and in_valid=0 in DONE, the next state SHALL be IDLE.
REQ-024 in_valid while in RUN SHALL be ignored; operands are not captured and upstream must hold them.
REQ-025 a, b and cin SHALL be sampled only on the accept edge; later input changes SHALL NOT affect an in-flight result.
REQ-026 The counter width SHALL be $clog2(WIDTH); it SHALL NOT wrap inside a single operation.

Reset
REQ-027 While rst=1 at a clock edge, the block SHALL set state=IDLE, sum=0, cout=0, counter=0, out_valid=0 and in_ready=1 after that edge.
REQ-028 Reset SHALL take priority over every handshake; a reset in RUN or DONE SHALL abort the operation with no result ever presented.
REQ-029 Capture is not allowed in a reset cycle: in_valid while rst=1 SHALL NOT be captured.

Verification (WIDTH=8)
REQ-030 Stimulus: a=0x00, b=0x00, cin=0, out_ready=1 -> response: sum=0x00, cout=0, with out_valid high exactly 9 cycles after the accept cycle.
REQ-031 Stimulus: a=0xFF, b=0x01, cin=0 -> response: sum=0x00, cout=1; and a=0xFF, b=0xFF, cin=1 -> response: sum=0xFF, cout=1.
REQ-032 Stimulus: a=0x5A, b=0x3C, cin=0, out_ready held 0 for 5 cycles in DONE -> response: sum=0x96, cout=0, stable and out_valid=1 throughout, then retired on out_ready=1.
REQ-033 Stimulus: back-to-back operands 0x12+0x34, then 0x80+0x80, with in_valid and out_ready kept at 1 -> response: 0x46/cout=0, then 0x00/cout=1, with no IDLE cycle between them.
REQ-034 Stimulus: rst=1 pulse 3 cycles after accepting 0xAA+0x55 -> response: out_valid stays 0 and in_ready=1 next cycle; a subsequent 0x01+0x01 gives 0x02/cout=0.
REQ-035 Stimulus: randomized loop of at least 1000 operand sets with random in_valid/out_ready -> response: every result matches {cout,sum}==a+b+cin, checked by assertions.
